fixed_to_binary16: RTL and testbench

Iterative converter from signed 16-bit two's-complement fixed-point to IEEE-754 binary16. It sits in front of the binary16 arithmetic datapath and produces the operands the binary16 adder and related units consume. These are normalized binary16 values, or +0. A valid/ready handshake on both sides lets it be chained with stall-capable producers and consumers.

---
 rtl/fixed_to_binary16.sv | 121 ++++++++++++
 tb/tb_fixed_to_binary16.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_binary16.sv
// Iterative signed Q(15-FRAC_BITS).FRAC_BITS to IEEE-754 binary16 converter with valid/ready on both sides.
// Rounding: define BINARY16_ROUND_NEAREST_EN for round-to-nearest-even, otherwise truncate toward zero.
module fixed_to_binary16 #(
  parameter int FRAC_BITS = 8
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] fixed_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  if (FRAC_BITS < 0 || FRAC_BITS > 14) begin : g_bad_frac_bits
    $error("fixed_to_binary16: FRAC_BITS must lie in 0..14");
  end

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  // Biased exponent of a value whose MSB sits at bit 15 of mag.
  localparam logic [5:0] EXP_INIT = 6'(30 - FRAC_BITS);

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [15:0] mag_q, mag_d;
  logic [5:0]  exp_q, exp_d;
  logic [15:0] result_q, result_d;
  logic        out_valid_q, out_valid_d;

  logic [9:0]  mant;
  logic        round_inc;
  logic [10:0] mant_sum;
  logic [4:0]  exp_fin;

  assign mant = mag_q[14:5];

`ifdef BINARY16_ROUND_NEAREST_EN
  logic guard, sticky;
  assign guard     = mag_q[4];
  assign sticky    = |mag_q[3:0];
  assign round_inc = guard & (sticky | mant[0]);
`else
  logic unused_round_bits;
  assign unused_round_bits = ^mag_q[4:0];
  assign round_inc         = 1'b0;
`endif

  // A carry out of the mantissa leaves mant_sum[9:0] at zero and bumps the exponent.
  assign mant_sum = {1'b0, mant} + {10'd0, round_inc};
  assign exp_fin  = exp_q[4:0] + {4'd0, mant_sum[10]};

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = fixed_in[15];
          mag_d  = fixed_in[15] ? (~fixed_in + 16'd1) : fixed_in;
          exp_d  = EXP_INIT;
          if (fixed_in == 16'h0000) begin
            result_d    = 16'h0000;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (!mag_q[15]) begin
          mag_d = {mag_q[14:0], 1'b0};
          exp_d = exp_q - 6'd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d    = {sign_q, exp_fin, mant_sum[9:0]};
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 16'h0000;
      exp_q       <= 6'd0;
      result_q    <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fixed_to_binary16.sv
// Directed and random checks of fixed_to_binary16 against an arithmetic binary16 reference model.
module tb_fixed_to_binary16;
  localparam int FRAC = 8;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [15:0] fixed_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] result;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  fixed_to_binary16 #(.FRAC_BITS(FRAC)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .fixed_in (fixed_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .result   (result),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Position of the most significant set bit of |v| (v nonzero).
  function automatic int msb_pos(input logic [15:0] v);
    int a, p;
    a = v[15] ? 65536 - int'(v) : int'(v);
    p = 0;
    while ((a >> (p + 1)) != 0) p++;
    return p;
  endfunction

  // Value = v * 2^-FRAC; binary16 = (-1)^s * 2^(e-15) * q/1024 with q in [1024, 2047].
  function automatic logic [15:0] ref_conv(input logic [15:0] v);
    int a, p, e, q, sh, rem, half;
    logic s;
    if (v == 16'h0000) return 16'h0000;
    s = v[15];
    a = s ? 65536 - int'(v) : int'(v);
    p = msb_pos(v);
    e = p - FRAC + 15;
    if (p >= 10) begin
      sh  = p - 10;
      q   = a >> sh;
      rem = a - (q << sh);
`ifdef BINARY16_ROUND_NEAREST_EN
      if (sh > 0) begin
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
      end
`else
      half = rem;
`endif
    end else begin
      q = a << (10 - p);
    end
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    return {s, e[4:0], q[9:0]};
  endfunction

  // Full transaction: accept v, check latency and result, hold for `stall` cycles, then handshake.
  task automatic convert(input logic [15:0] v, input int stall, input string tag);
    int n, lat_exp;
    logic [15:0] exp_res;
    exp_res = ref_conv(v);
    lat_exp = (v == 16'h0000) ? 0 : 17 - msb_pos(v);
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    fixed_in = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    fixed_in = 16'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_latency"}, n, lat_exp);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    chk({tag, "_no_ready_in_done"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      fixed_in = 16'($urandom);
      step();
      chk({tag, "_stall_result"}, {16'd0, result}, {16'd0, exp_res});
      chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_dropped"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] rv;
    rst       = 1'b1;
    fixed_in  = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", {16'd0, result}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    convert(16'h0100, 0, "one");
    chk("one_const", {16'd0, dut.result}, 32'h3C00);
    convert(16'hFF00, 0, "neg_one");
    chk("neg_one_const", {16'd0, result}, 32'hBC00);
    convert(16'h8000, 0, "min_neg");
    chk("min_neg_const", {16'd0, result}, 32'hD800);
    convert(16'h0000, 0, "zero");
    chk("zero_const", {16'd0, result}, 32'h0000);
    convert(16'h7FFF, 0, "max_pos");
`ifdef BINARY16_ROUND_NEAREST_EN
    chk("max_pos_const", {16'd0, result}, 32'h5800);
`else
    chk("max_pos_const", {16'd0, result}, 32'h57FF);
`endif
    convert(16'h0001, 0, "lsb");
    convert(16'hFFFF, 0, "neg_lsb");
    convert(16'h0123, 5, "backpressure");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_queued_conv", {31'd0, out_valid}, 32'd0);
    end

    fixed_in = 16'h0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    chk("mid_rst_in_ready_back", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mid_rst_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    convert(16'h0100, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      rv = 16'($urandom);
      if (i % 7 == 0) rv = 16'($urandom_range(0, 15));
      if (i % 11 == 0) rv = 16'h0000;
      convert(rv, int'($urandom_range(0, 3)), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
